// File: rtl/arb_rr4_sel.sv
// Round-robin arbiter for four requesters that drives the enable/select inputs of a 2-to-4 decoder.
// Optional per-grant hold limit is enabled by defining ARB_TIMEOUT_EN.
module arb_rr4_sel #(
  parameter logic [1:0] RESET_PTR = 2'd3,
  parameter int         TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic       E,
  output logic [1:0] A,
  output logic       busy,
  output logic [7:0] gcnt
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [1:0] a_q, a_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] gcnt_q, gcnt_d;

  logic [1:0] cand [4];
  logic [3:0] hit;
  logic [1:0] pick_idx;
  logic       any_req;
  logic       tmo_hit;
  logic       release_grant;

  // cand[0] is the highest-priority slot: the requester just after the last grant.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_scan
      assign cand[gi] = ptr_q + 2'(gi + 1);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    pick_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) pick_idx = cand[k];
    end
  end

  assign any_req = |req;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  assign tmo_hit = (hold_q == 8'(TIMEOUT - 1));

  always_comb begin
    hold_d = hold_q;
    if (state_q == IDLE) begin
      if (any_req) hold_d = 8'd0;
    end else begin
      hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= 8'd0;
    else     hold_q <= hold_d;
  end
`else
  wire unused_timeout = ^8'(TIMEOUT);
  assign tmo_hit = 1'b0;
`endif

  assign release_grant = done | ~req[a_q] | tmo_hit;

  // A only moves on IDLE->GRANT, so the decoder never sees the select change while enabled.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    ptr_d   = ptr_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          a_d     = pick_idx;
          ptr_d   = pick_idx;
          gcnt_d  = gcnt_q + 8'd1;
        end
      end
      default: begin
        if (release_grant) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 2'd0;
      ptr_q   <= RESET_PTR;
      gcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      ptr_q   <= ptr_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign E    = (state_q == GRANT);
  assign busy = (state_q == GRANT);
  assign A    = a_q;
  assign gcnt = gcnt_q;

endmodule

// File: tb/tb_arb_rr4_sel.sv
// Scoreboard bench for arb_rr4_sel: stimulus pushes expected post-edge outputs, a monitor pops and compares.
module tb_arb_rr4_sel;

  logic       clk = 1'b1;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       E;
  logic [1:0] A;
  logic       busy;
  logic [7:0] gcnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic       e;
    logic [1:0] a;
    logic [7:0] g;
  } exp_t;

  exp_t sb_q[$];

  arb_rr4_sel #(.RESET_PTR(2'd3), .TIMEOUT(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .done (done),
    .E    (E),
    .A    (A),
    .busy (busy),
    .gcnt (gcnt)
  );

  always #5 clk = ~clk;

  // Apply inputs for the next edge and queue the outputs expected after it.
  task automatic step(input string name, input logic r, input logic [3:0] rq, input logic d,
                      input logic e, input logic [1:0] a, input logic [7:0] g);
    exp_t x;
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    x.name = name;
    x.e    = e;
    x.a    = a;
    x.g    = g;
    sb_q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        total++;
        if (E !== x.e || busy !== x.e || A !== x.a || gcnt !== x.g) begin
          bad++;
          $display("FAIL %s: got E=%b busy=%b A=%b gcnt=%0d, want E=%b busy=%b A=%b gcnt=%0d",
                   x.name, E, busy, A, gcnt, x.e, x.e, x.a, x.g);
        end else begin
          $display("ok   %s: E=%b A=%b gcnt=%0d", x.name, E, A, gcnt);
        end
      end
    end
  end

  initial begin : stim
    logic [1:0] a_m;
    logic [7:0] g_m;
    int         waited;
    rst = 1'b1; req = 4'b0000; done = 1'b0;

    step("reset0", 1, 4'b0000, 0, 0, 2'd0, 8'd0);
    step("reset1", 1, 4'b0000, 0, 0, 2'd0, 8'd0);
    step("idle_noreq", 0, 4'b0000, 0, 0, 2'd0, 8'd0);
    step("grant_r0", 0, 4'b0001, 0, 1, 2'd0, 8'd1);
    step("hold_r0", 0, 4'b0001, 0, 1, 2'd0, 8'd1);
    step("done_r0", 0, 4'b0001, 1, 0, 2'd0, 8'd1);
    step("idle_done_ign", 0, 4'b0000, 1, 0, 2'd0, 8'd1);
    step("idle_hold_a", 0, 4'b0000, 0, 0, 2'd0, 8'd1);

    // Fresh rotation with all four requesting
    step("rst_rot", 1, 4'b0000, 0, 0, 2'd0, 8'd0);
    step("rot_g0", 0, 4'b1111, 0, 1, 2'd0, 8'd1);
    step("rot_r0", 0, 4'b1111, 1, 0, 2'd0, 8'd1);
    step("rot_g1", 0, 4'b1111, 0, 1, 2'd1, 8'd2);
    step("rot_r1", 0, 4'b1111, 1, 0, 2'd1, 8'd2);
    step("rot_g2", 0, 4'b1111, 0, 1, 2'd2, 8'd3);
    step("rot_r2", 0, 4'b1111, 1, 0, 2'd2, 8'd3);
    step("rot_g3", 0, 4'b1111, 0, 1, 2'd3, 8'd4);
    step("rot_r3", 0, 4'b1111, 1, 0, 2'd3, 8'd4);
    step("rot_g0b", 0, 4'b1111, 0, 1, 2'd0, 8'd5);
    step("rot_r0b", 0, 4'b1111, 1, 0, 2'd0, 8'd5);

    // Pointer after grant to 1 makes 2 win over 0
    step("g1_only", 0, 4'b0010, 0, 1, 2'd1, 8'd6);
    step("r1_only", 0, 4'b0010, 1, 0, 2'd1, 8'd6);
    step("ptr_0101", 0, 4'b0101, 0, 1, 2'd2, 8'd7);

    // Granted bit drops without done
    step("req_drop", 0, 4'b0001, 0, 0, 2'd2, 8'd7);
    step("g0_after_drop", 0, 4'b0001, 0, 1, 2'd0, 8'd8);
    step("done_and_new", 0, 4'b1000, 1, 0, 2'd0, 8'd8);
    step("g3_late", 0, 4'b1000, 0, 1, 2'd3, 8'd9);
    step("grant_ignores", 0, 4'b1111, 0, 1, 2'd3, 8'd9);

    // Reset in the middle of a grant to 2
    step("r3", 0, 4'b0000, 1, 0, 2'd3, 8'd9);
    step("g2", 0, 4'b0100, 0, 1, 2'd2, 8'd10);
    step("rst_mid", 1, 4'b0100, 0, 0, 2'd0, 8'd0);
    step("post_rst_g0", 0, 4'b1111, 0, 1, 2'd0, 8'd1);

    // gcnt wrap: 256 more release/grant pairs with all requesting
    a_m = 2'd0;
    g_m = 8'd1;
    for (int i = 0; i < 256; i++) begin
      step("wrap_rel", 0, 4'b1111, 1, 0, a_m, g_m);
      a_m = a_m + 2'd1;
      g_m = g_m + 8'd1;
      step("wrap_gnt", 0, 4'b1111, 0, 1, a_m, g_m);
    end

    // Long hold on requester 2 with no done
    step("tmo_rst", 1, 4'b0000, 0, 0, 2'd0, 8'd0);
    step("tmo_g", 0, 4'b0100, 0, 1, 2'd2, 8'd1);
`ifdef ARB_TIMEOUT_EN
    step("tmo_h2", 0, 4'b0100, 0, 1, 2'd2, 8'd1);
    step("tmo_h3", 0, 4'b0100, 0, 1, 2'd2, 8'd1);
    step("tmo_h4", 0, 4'b0100, 0, 1, 2'd2, 8'd1);
    step("tmo_rel", 0, 4'b0100, 0, 0, 2'd2, 8'd1);
    step("tmo_regrant", 0, 4'b0100, 0, 1, 2'd2, 8'd2);
`else
    for (int i = 0; i < 20; i++) begin
      step("no_tmo_hold", 0, 4'b0100, 0, 1, 2'd2, 8'd1);
    end
`endif
    step("final_rel", 0, 4'b0100, 1, 0, 2'd2, 8'(sb_q.size() >= 0 ? 0 : 0) == 8'd0 ?
`ifdef ARB_TIMEOUT_EN
         8'd2
`else
         8'd1
`endif
         : 8'd0);

    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
